// File: rtl/cmd_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : cmd_ctrl_pkg
// Description : Shared constants and state encoding for the command frame
//               controller: opcodes, error response code, FSM states and the
//               register-file addresses that hold the ALU operands.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cmd_ctrl_pkg;

  // Frame opcodes, carried in the low 8 bits of the first frame word
  localparam logic [7:0] OP_WR    = 8'hAA;
  localparam logic [7:0] OP_RD    = 8'hBB;
  localparam logic [7:0] OP_ALU   = 8'hCC;
  localparam logic [7:0] OP_NOP   = 8'hDD;

  // Word pushed to the TX FIFO when error responses are enabled
  localparam logic [7:0] ERR_CODE = 8'hEE;

  // Register-file locations that feed the ALU operands
  localparam int unsigned RF_OPA_ADDR = 0;
  localparam int unsigned RF_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_OPA  = 4'd5,
    ST_ALU_OPB  = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX       = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
//------------------------------------------------------------------------------
// Module      : cmd_timeout_cnt
// Description : Idle-cycle counter for the frame timeout. Counts while enabled,
//               restarts on clear, and flags the terminal count
//               TIMEOUT_CYCLES-1. TIMEOUT_CYCLES = 0 removes the counter and
//               holds the terminal-count output low.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cmd_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign tc = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CW-1:0] cnt;

      // Count idle cycles; any clear or leaving a timed state restarts from zero
      always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign tc = en && (cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cmd_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module      : cmd_frame_ctrl
// Description : UART command frame controller. Decodes write, read and ALU
//               frames, issues register-file and ALU strobes, and streams
//               responses into the TX FIFO under FIFO_FULL backpressure.
//               Mid-frame silence longer than TIMEOUT_CYCLES aborts the frame.
//               Optional macro CMD_ERR_RSP_EN: an unknown opcode or a timeout
//               abort also pushes ERR_CODE to the FIFO.
//               ADDR_WIDTH and FUN_WIDTH must not exceed DATA_WIDTH.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cmd_frame_ctrl
  import cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic                    FIFO_FULL,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLKG_EN,
  output logic                    CLKDIV_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY,
  output logic                    FRAME_ERR
);

  state_t                  state, state_nxt;
  logic [2*DATA_WIDTH-1:0] tx_buf, tx_buf_nxt;
  logic [1:0]              tx_left, tx_left_nxt;

  logic                    rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt;
  logic [ADDR_WIDTH-1:0]   rf_addr_nxt;
  logic [DATA_WIDTH-1:0]   rf_wr_data_nxt, tx_p_data_nxt;
  logic [FUN_WIDTH-1:0]    alu_fun_nxt;
  logic                    tx_d_vld_nxt, frame_err_nxt, clkg_en_nxt;

  logic                    rx_accept, err_evt;
  logic                    timeout_en, timeout_clr, timeout_tc;

  // Every state except IDLE and TX is subject to the inter-word timeout
  assign timeout_en  = (state != ST_IDLE) && (state != ST_TX);
  assign timeout_clr = rx_accept || (state_nxt != state);

  cmd_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (CLK),
    .rst (RST),
    .clr (timeout_clr),
    .en  (timeout_en),
    .tc  (timeout_tc)
  );

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_nxt      = state;
    tx_buf_nxt     = tx_buf;
    tx_left_nxt    = tx_left;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    rf_addr_nxt    = RF_ADDR;
    rf_wr_data_nxt = RF_WR_DATA;
    alu_en_nxt     = 1'b0;
    alu_fun_nxt    = ALU_FUN;
    tx_p_data_nxt  = TX_P_DATA;
    tx_d_vld_nxt   = 1'b0;
    frame_err_nxt  = 1'b0;
    rx_accept      = 1'b0;
    err_evt        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          rx_accept = 1'b1;
          case (RX_P_DATA[7:0])
            OP_WR:   state_nxt = ST_WR_ADDR;
            OP_RD:   state_nxt = ST_RD_ADDR;
            OP_ALU:  state_nxt = ST_ALU_OPA;
            OP_NOP:  state_nxt = ST_ALU_FUN;
            default: err_evt   = 1'b1;
          endcase
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          rx_accept   = 1'b1;
          rf_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rx_accept      = 1'b1;
          rf_wr_data_nxt = RX_P_DATA;
          rf_wr_en_nxt   = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rx_accept    = 1'b1;
          rf_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_nxt = 1'b1;
          state_nxt    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RF_RD_DATA_VLD) begin
          tx_buf_nxt  = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
          tx_left_nxt = 2'd1;
          state_nxt   = ST_TX;
        end
      end
      ST_ALU_OPA: begin
        if (RX_D_VLD) begin
          rx_accept      = 1'b1;
          rf_addr_nxt    = ADDR_WIDTH'(RF_OPA_ADDR);
          rf_wr_data_nxt = RX_P_DATA;
          rf_wr_en_nxt   = 1'b1;
          state_nxt      = ST_ALU_OPB;
        end
      end
      ST_ALU_OPB: begin
        if (RX_D_VLD) begin
          rx_accept      = 1'b1;
          rf_addr_nxt    = ADDR_WIDTH'(RF_OPB_ADDR);
          rf_wr_data_nxt = RX_P_DATA;
          rf_wr_en_nxt   = 1'b1;
          state_nxt      = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          rx_accept   = 1'b1;
          alu_fun_nxt = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_nxt  = 1'b1;
          state_nxt   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          tx_buf_nxt  = ALU_OUT;
          tx_left_nxt = 2'd2;
          state_nxt   = ST_TX;
        end
      end
      ST_TX: begin
        // Push decision uses FIFO_FULL as sampled at the launching edge;
        // a held word stays at the bottom of tx_buf until it goes out
        if (!FIFO_FULL) begin
          tx_d_vld_nxt  = 1'b1;
          tx_p_data_nxt = tx_buf[DATA_WIDTH-1:0];
          tx_buf_nxt    = tx_buf >> DATA_WIDTH;
          tx_left_nxt   = tx_left - 2'd1;
          if (tx_left == 2'd1) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A word or result arriving on the terminal-count cycle keeps the frame
    if (timeout_tc && !rx_accept && (state_nxt == state)) begin
      state_nxt = ST_IDLE;
      err_evt   = 1'b1;
    end

    if (err_evt) begin
      frame_err_nxt = 1'b1;
`ifdef CMD_ERR_RSP_EN
      tx_buf_nxt    = (2*DATA_WIDTH)'(ERR_CODE);
      tx_left_nxt   = 2'd1;
      state_nxt     = ST_TX;
`endif
    end

    clkg_en_nxt = (state_nxt == ST_ALU_FUN) || (state_nxt == ST_ALU_WAIT);
  end

  // State and output registers; reset clears everything in the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      tx_buf     <= '0;
      tx_left    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLKG_EN    <= 1'b0;
      CLKDIV_EN  <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_buf     <= tx_buf_nxt;
      tx_left    <= tx_left_nxt;
      RF_WR_EN   <= rf_wr_en_nxt;
      RF_RD_EN   <= rf_rd_en_nxt;
      RF_ADDR    <= rf_addr_nxt;
      RF_WR_DATA <= rf_wr_data_nxt;
      ALU_EN     <= alu_en_nxt;
      ALU_FUN    <= alu_fun_nxt;
      CLKG_EN    <= clkg_en_nxt;
      CLKDIV_EN  <= 1'b1;
      TX_P_DATA  <= tx_p_data_nxt;
      TX_D_VLD   <= tx_d_vld_nxt;
      BUSY       <= (state_nxt != ST_IDLE);
      FRAME_ERR  <= frame_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_cmd_frame_ctrl
// Description : Directed self-checking bench for cmd_frame_ctrl. Expected
//               values are hand-computed; the CMD_ERR_RSP_EN macro selects the
//               error-response expectations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmd_frame_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned FW = 4;
  localparam int unsigned TO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          FIFO_FULL;
  logic [DW-1:0] RF_RD_DATA;
  logic          RF_RD_DATA_VLD;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VLD;
  logic          RF_WR_EN, RF_RD_EN, ALU_EN, CLKG_EN, CLKDIV_EN, TX_D_VLD, BUSY, FRAME_ERR;
  logic [AW-1:0] RF_ADDR;
  logic [DW-1:0] RF_WR_DATA, TX_P_DATA;
  logic [FW-1:0] ALU_FUN;

  cmd_frame_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .FIFO_FULL(FIFO_FULL), .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .RF_WR_EN(RF_WR_EN),
    .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Event log sampled mid-cycle
  logic [DW-1:0] push_q[$];
  logic [AW-1:0] wra_q[$];
  logic [DW-1:0] wrd_q[$];
  int alu_en_n = 0;
  int rd_en_n  = 0;
  int ferr_n   = 0;

  always @(negedge CLK) begin
    if (TX_D_VLD) push_q.push_back(TX_P_DATA);
    if (RF_WR_EN) begin
      wra_q.push_back(RF_ADDR);
      wrd_q.push_back(RF_WR_DATA);
    end
    if (ALU_EN)    alu_en_n = alu_en_n + 1;
    if (RF_RD_EN)  rd_en_n  = rd_en_n + 1;
    if (FRAME_ERR) ferr_n   = ferr_n + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLKG_EN,
            CLKDIV_EN, TX_P_DATA, TX_D_VLD, BUSY, FRAME_ERR};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, w0, a0, f0;
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; FIFO_FULL = 1'b0;
    RF_RD_DATA = '0; RF_RD_DATA_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    tick(); tick();
    check("reset_outs", all_outs(), 32'h0);
    RST = 1'b0;
    tick();
    check("clkdiv_after_reset", {31'd0, CLKDIV_EN}, 32'd1);
    check("busy_idle", {31'd0, BUSY}, 32'd0);

    // 1. write then read back
    send(8'hAA);
    check("busy_in_frame", {31'd0, BUSY}, 32'd1);
    send(8'h05);
    send(8'h3C);
    check("wr_strobe", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {19'd0, 1'b1, 4'h5, 8'h3C});
    check("busy_after_wr", {31'd0, BUSY}, 32'd0);
    send(8'hBB);
    send(8'h05);
    check("rd_strobe", {RF_RD_EN, RF_ADDR}, {27'd0, 1'b1, 4'h5});
    tick(); tick();
    RF_RD_DATA = 8'h3C; RF_RD_DATA_VLD = 1'b1;
    tick();
    RF_RD_DATA_VLD = 1'b0;
    tick();
    check("rd_push", {TX_D_VLD, TX_P_DATA}, {23'd0, 1'b1, 8'h3C});
    tick();
    check("rd_push_once", {TX_D_VLD, BUSY}, 32'd0);
    check("rd_push_count", push_q.size(), 1);
    check("rd_en_count", rd_en_n, 1);
    check("wr_count_t1", wra_q.size(), 1);

    // 2. ALU with operands
    p0 = push_q.size(); w0 = wra_q.size(); a0 = alu_en_n;
    send(8'hCC); send(8'h0A); send(8'h14);
    check("clkg_fun_state", {31'd0, CLKG_EN}, 32'd1);
    send(8'h00);
    check("alu_strobe", {ALU_EN, ALU_FUN, CLKG_EN}, {26'd0, 1'b1, 4'h0, 1'b1});
    tick(); tick(); tick();
    check("clkg_wait", {31'd0, CLKG_EN}, 32'd1);
    ALU_OUT = 16'h001E; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    check("clkg_off", {31'd0, CLKG_EN}, 32'd0);
    repeat (4) tick();
    check("alu_push_count", push_q.size(), p0 + 2);
    check("alu_push_lo", push_q[p0], 32'h1E);
    check("alu_push_hi", push_q[p0+1], 32'h00);
    check("opa_write", {wra_q[w0], wrd_q[w0]}, {20'd0, 4'h0, 8'h0A});
    check("opb_write", {wra_q[w0+1], wrd_q[w0+1]}, {20'd0, 4'h1, 8'h14});
    check("alu_en_count", alu_en_n, a0 + 1);
    check("busy_after_alu", {31'd0, BUSY}, 32'd0);

    // 3. NOP frame with backpressure
    p0 = push_q.size(); w0 = wra_q.size();
    FIFO_FULL = 1'b1;
    send(8'hDD); send(8'h02);
    check("nop_fun", {ALU_EN, ALU_FUN}, {27'd0, 1'b1, 4'h2});
    tick();
    ALU_OUT = 16'h3412; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    repeat (5) tick();
    check("held_no_push", push_q.size(), p0);
    check("held_busy", {31'd0, BUSY}, 32'd1);
    FIFO_FULL = 1'b0;
    repeat (4) tick();
    check("bp_push_count", push_q.size(), p0 + 2);
    check("bp_push_lo", push_q[p0], 32'h12);
    check("bp_push_hi", push_q[p0+1], 32'h34);
    check("nop_no_rf_write", wra_q.size(), w0);

    // 4. timeout abort, then word on the terminal-count cycle
    p0 = push_q.size(); w0 = wra_q.size(); f0 = ferr_n;
    send(8'hAA); send(8'h03);
    repeat (TO - 1) tick();
    check("pre_timeout", {BUSY, FRAME_ERR}, {30'd0, 1'b1, 1'b0});
    tick();
`ifdef CMD_ERR_RSP_EN
    check("timeout_abort", {BUSY, FRAME_ERR}, {30'd0, 1'b1, 1'b1});
`else
    check("timeout_abort", {BUSY, FRAME_ERR}, {30'd0, 1'b0, 1'b1});
`endif
    tick();
    check("ferr_one_cycle", {31'd0, FRAME_ERR}, 32'd0);
    repeat (3) tick();
    check("timeout_no_write", wra_q.size(), w0);
    check("busy_after_abort", {31'd0, BUSY}, 32'd0);
`ifdef CMD_ERR_RSP_EN
    check("timeout_err_push", push_q.size(), p0 + 1);
    check("timeout_err_word", push_q[p0], 32'hEE);
`else
    check("timeout_no_push", push_q.size(), p0);
`endif
    send(8'hAA); send(8'h03);
    repeat (TO - 1) tick();
    send(8'h77);
    check("tc_word_wins", {RF_WR_EN, RF_ADDR, RF_WR_DATA, FRAME_ERR}, {18'd0, 1'b1, 4'h3, 8'h77, 1'b0});
    tick();
    check("tc_ferr_count", ferr_n, f0 + 1);

    // 5. unknown opcode
    p0 = push_q.size();
    send(8'h55);
    check("unknown_ferr", {31'd0, FRAME_ERR}, 32'd1);
    repeat (4) tick();
`ifdef CMD_ERR_RSP_EN
    check("unknown_push", push_q.size(), p0 + 1);
    check("unknown_word", push_q[p0], 32'hEE);
`else
    check("unknown_no_push", push_q.size(), p0);
`endif
    check("unknown_idle", {31'd0, BUSY}, 32'd0);

    // 6. reset while waiting on the ALU
    p0 = push_q.size(); w0 = wra_q.size();
    send(8'hCC); send(8'h01); send(8'h02); send(8'h03);
    tick(); tick();
    check("in_alu_wait", {BUSY, CLKG_EN}, {30'd0, 1'b1, 1'b1});
    RST = 1'b1;
    tick();
    check("midop_reset_outs", all_outs(), 32'h0);
    RST = 1'b0;
    tick();
    check("post_reset", {CLKDIV_EN, BUSY}, {30'd0, 1'b1, 1'b0});
    ALU_OUT = 16'hFFFF; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    repeat (3) tick();
    check("no_push_after_reset", push_q.size(), p0);
    send(8'hAA); send(8'h09); send(8'h5A);
    check("wr_after_reset", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {19'd0, 1'b1, 4'h9, 8'h5A});
    tick();
    check("wr_count_t6", wra_q.size(), w0 + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
